dance_matrix_scanner: RTL and testbench
=======================================

DANCE_MATRIX_SCANNER -- requirements
Module: dance_matrix_scanner

Interface
REQ-001 SHALL have parameter COLS, default 16: matrix columns scanned; power of two, at least 2.
REQ-002 SHALL have parameter ROWS, default 16: row-drive width.
REQ-003 SHALL have parameter NUM_TARGETS, default 4: number of target glyphs; power of two, 2..16. TW = clog2(NUM_TARGETS).
REQ-004 SHALL have parameter FRAME_DIV, default 256: clk cycles per frame tick; at least 2.
REQ-005 SHALL have parameter CELEB_FRAMES, default 8: frame ticks spent in celebration.
REQ-006 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 rand_num  input  TW  random target candidate; sampled only on a frame tick in SHOW.
REQ-009 key_valid  input  1  one-cycle key-press strobe.
REQ-010 key_idx  input  TW  index of the pressed key; qualified by key_valid.
REQ-011 col_sel  output  clog2(COLS)  current scan column.
REQ-012 row_n  output  ROWS  active-low row pattern for col_sel.
REQ-013 target  output  TW  currently displayed target.
REQ-014 hit_pulse  output  1  one-cycle strobe on a correct key.
REQ-015 miss_pulse  output  1  one-cycle strobe on a wrong key.
REQ-016 score  output  8  count of hits.

Function
REQ-017 col_sel SHALL increment every cycle and wrap from COLS-1 to 0.
REQ-018 Frame divider SHALL count 0..FRAME_DIV-1 and wrap. A frame tick is the cycle in which the divider equals FRAME_DIV-1.
REQ-019 FSM states SHALL be SHOW and CELEB.
REQ-020 In SHOW, on a frame tick with no hit in the same cycle, target SHALL load rand_num on the next edge.
REQ-021 In SHOW, key_valid with key_idx==target SHALL cause all of the following on the next edge:
- hit_pulse=1 for exactly one cycle;
- state goes to CELEB;
- the celebration frame counter clears.
REQ-022 In SHOW, key_valid with key_idx!=target SHALL give miss_pulse=1 for one cycle on the next edge; state SHALL stay SHOW.
REQ-023 If a hit and a frame tick occur in the same cycle, the key SHALL be compared with the pre-tick target, the hit wins, and target SHALL NOT update.
REQ-024 In CELEB, key_valid SHALL be ignored: no pulse, no score change.
REQ-025 In CELEB, each frame tick SHALL toggle anim_phase and increment the celebration counter.
REQ-026 On the CELEB_FRAMES-th tick, the FSM SHALL return to SHOW, and target SHALL load rand_num on that same edge.
REQ-027 row_n SHALL be combinational from col_sel, state, anim_phase and target, with zero latency relative to col_sel:
- SHOW: the glyph of target;
- CELEB: celebration glyph A when anim_phase=0, glyph B when anim_phase=1.
REQ-028 Columns outside a glyph's defined area SHALL drive row_n all ones (all rows off).

Reset
REQ-029 On rst, the following SHALL be cleared on the next edge:
- state=SHOW, col_sel=0, divider=0, target=0, anim_phase=0, celebration counter=0;
- hit_pulse=0, miss_pulse=0, score=0.
REQ-030 rst SHALL override every other input in the same cycle, including mid-CELEB.
REQ-031 rst SHALL suppress a key_valid or frame tick that coincides with it.

Configuration
REQ-032 Macro DANCE_SCORE_EN:
- When defined, score SHALL increment by 1 per hit and saturate at 255.
- When undefined, score SHALL be tied to 0, and no score register SHALL be synthesized.
- hit_pulse and miss_pulse SHALL behave identically in both builds.

Structure
REQ-033 A shared package dance_pkg SHALL hold:
- the FSM state enum;
- the glyph row type (ROWS-bit vector);
- the celebration glyph constants A and B;
- the default target glyph table.
REQ-034 A sub-module dance_glyph_rom SHALL map (glyph select, col_sel) to row_n combinationally; the top holds the counters, FSM and score.

Verification (COLS=16, ROWS=16, NUM_TARGETS=4, FRAME_DIV=4, CELEB_FRAMES=2)
REQ-035 Reset check:
- Stimulus: rst=1 for 2 cycles, then release.
- Response: col_sel counts 0,1,..,15,0; target=0; score=0; row_n shows the glyph for target 0.
REQ-036 Target load:
- Stimulus: rand_num=2 held.
- Response: target=2 after the first frame tick (cycle 4 after reset); row_n matches the glyph-2 table for all 16 columns.
- Also check: the following frame ticks occur 4 cycles apart.
REQ-037 Hit and celebration:
- Stimulus: target=2; key_valid=1 with key_idx=2.
- Response: hit_pulse for one cycle; score=1; state CELEB.
- Then: row_n alternates between glyphs A and B at successive ticks; after 2 ticks, state returns to SHOW and target=rand_num.
REQ-038 Miss and ignore:
- Stimulus: key_idx=1 while target=2.
- Response: miss_pulse=1 for one cycle; score unchanged.
- Then: a key pressed during CELEB produces no pulse.
REQ-039 Simultaneous hit and tick:
- Stimulus: key_valid with the correct key_idx in the frame-tick cycle, with rand_num=3.
- Response: hit_pulse=1; target unchanged; CELEB entered.
REQ-040 Saturation and mid-CELEB reset:
- Stimulus: 260 hits.
- Response with DANCE_SCORE_EN defined: score=255. Response without it: score=0.
- Then: rst during CELEB returns to SHOW with target=0 on the next edge.

Source files
------------

// File: rtl/dance_pkg.sv
// Shared types and glyph tables for the dance matrix scanner.
// Glyphs are stored as active-high pixel columns; bit r lights row r.
package dance_pkg;

    localparam int unsigned GLYPH_ROWS      = 16;
    localparam int unsigned GLYPH_COLS      = 8;
    localparam int unsigned DEFAULT_TARGETS = 4;

    typedef enum logic {
        StShow,
        StCeleb
    } dance_state_e;

    typedef enum logic [1:0] {
        GlyphTarget,
        GlyphCelebA,
        GlyphCelebB
    } glyph_kind_e;

    typedef logic [GLYPH_ROWS-1:0] glyph_row_t;

    // Checkerboard pair; A and B are pixel-inverses so the toggle is obvious.
    localparam glyph_row_t CELEB_GLYPH_A [GLYPH_COLS] = '{
        16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555,
        16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555
    };

    localparam glyph_row_t CELEB_GLYPH_B [GLYPH_COLS] = '{
        16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA,
        16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA
    };

    // Arrow glyphs: 0 up, 1 down, 2 right, 3 left. Column 0 first.
    localparam glyph_row_t TARGET_GLYPHS [DEFAULT_TARGETS][GLYPH_COLS] = '{
        '{16'h0180, 16'h03C0, 16'h07E0, 16'h0FF0,
          16'h0180, 16'h0180, 16'h0180, 16'h0180},
        '{16'h0180, 16'h0180, 16'h0180, 16'h0180,
          16'h0FF0, 16'h07E0, 16'h03C0, 16'h0180},
        '{16'h0010, 16'h0030, 16'h0070, 16'h0FF0,
          16'h0FF0, 16'h0070, 16'h0030, 16'h0010},
        '{16'h0800, 16'h0C00, 16'h0E00, 16'h0FF0,
          16'h0FF0, 16'h0E00, 16'h0C00, 16'h0800}
    };

endpackage

// File: rtl/dance_glyph_rom.sv
// Combinational glyph lookup: (glyph select, target index, column) -> active-low rows.
// Columns past the glyph width and rows past the glyph height are driven off.
module dance_glyph_rom
    import dance_pkg::*;
#(
    parameter int unsigned COLS        = 16,
    parameter int unsigned ROWS        = 16,
    parameter int unsigned NUM_TARGETS = 4,
    localparam int unsigned CW         = $clog2(COLS),
    localparam int unsigned TW         = $clog2(NUM_TARGETS)
) (
    input  logic [1:0]      glyph_sel,
    input  logic [TW-1:0]   glyph_idx,
    input  logic [CW-1:0]   col_sel,
    output logic [ROWS-1:0] row_n
);

    localparam int unsigned GCW = $clog2(GLYPH_COLS);

    glyph_row_t     px;
    logic [GCW-1:0] gcol;
    logic [1:0]     tsel;

    // Pick the pixel column, then invert into the active-low row drive.
    always_comb begin
        px   = '0;
        gcol = GCW'(col_sel);
        // Targets beyond the default table reuse it modulo its size.
        tsel = 2'(glyph_idx);
        if (32'(col_sel) < GLYPH_COLS) begin
            case (glyph_kind_e'(glyph_sel))
                GlyphCelebA: px = CELEB_GLYPH_A[gcol];
                GlyphCelebB: px = CELEB_GLYPH_B[gcol];
                default:     px = TARGET_GLYPHS[tsel][gcol];
            endcase
        end
        row_n = ~ROWS'(px);
    end

endmodule

// File: rtl/dance_matrix_scanner.sv
// Dance-pad matrix scanner: column scan, frame divider, SHOW/CELEB game FSM.
// Optional build macro DANCE_SCORE_EN adds a saturating 8-bit hit score;
// without it score is tied to zero.
module dance_matrix_scanner
    import dance_pkg::*;
#(
    parameter int unsigned COLS         = 16,
    parameter int unsigned ROWS         = 16,
    parameter int unsigned NUM_TARGETS  = 4,
    parameter int unsigned FRAME_DIV    = 256,
    parameter int unsigned CELEB_FRAMES = 8,
    localparam int unsigned CW          = $clog2(COLS),
    localparam int unsigned TW          = $clog2(NUM_TARGETS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [TW-1:0]   rand_num,
    input  logic            key_valid,
    input  logic [TW-1:0]   key_idx,
    output logic [CW-1:0]   col_sel,
    output logic [ROWS-1:0] row_n,
    output logic [TW-1:0]   target,
    output logic            hit_pulse,
    output logic            miss_pulse,
    output logic [7:0]      score
);

    localparam int unsigned DW  = $clog2(FRAME_DIV);
    localparam int unsigned CCW = (CELEB_FRAMES > 1) ? $clog2(CELEB_FRAMES + 1) : 1;

    logic [CW-1:0]  col_q;
    logic [DW-1:0]  div_q;
    logic           frame_tick;
    logic           key_hit;

    dance_state_e   state_q, state_d;
    logic [TW-1:0]  target_q, target_d;
    logic           anim_q, anim_d;
    logic [CCW-1:0] celeb_cnt_q, celeb_cnt_d;
    logic           hit_q, hit_d;
    logic           miss_q, miss_d;
    logic [1:0]     glyph_sel;

    assign frame_tick = (div_q == DW'(FRAME_DIV - 1));
    assign key_hit    = key_valid && (key_idx == target_q);

    // Free-running column scan and frame divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            div_q <= '0;
        end else begin
            col_q <= col_q + CW'(1);
            div_q <= frame_tick ? '0 : div_q + DW'(1);
        end
    end

    // Game FSM next-state and pulse generation.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        anim_d      = anim_q;
        celeb_cnt_d = celeb_cnt_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        case (state_q)
            StShow: begin
                if (key_valid) begin
                    if (key_hit) begin
                        hit_d       = 1'b1;
                        state_d     = StCeleb;
                        celeb_cnt_d = '0;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
                // A hit on the tick cycle keeps the target the player just matched.
                if (frame_tick && !key_hit) begin
                    target_d = rand_num;
                end
            end
            StCeleb: begin
                if (frame_tick) begin
                    anim_d      = ~anim_q;
                    celeb_cnt_d = celeb_cnt_q + CCW'(1);
                    if (celeb_cnt_q == CCW'(CELEB_FRAMES - 1)) begin
                        state_d  = StShow;
                        target_d = rand_num;
                    end
                end
            end
            default: state_d = StShow;
        endcase
    end

    // FSM and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StShow;
            target_q    <= '0;
            anim_q      <= 1'b0;
            celeb_cnt_q <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            anim_q      <= anim_d;
            celeb_cnt_q <= celeb_cnt_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

`ifdef DANCE_SCORE_EN
    logic [7:0] score_q;

    // Score advances on the same edge that raises hit_pulse, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
        end else if (hit_d && (score_q != 8'hFF)) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign score = score_q;
`else
    assign score = 8'd0;
`endif

    assign glyph_sel  = (state_q == StShow) ? GlyphTarget :
                        (anim_q ? GlyphCelebB : GlyphCelebA);
    assign col_sel    = col_q;
    assign target     = target_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;

    dance_glyph_rom #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .NUM_TARGETS (NUM_TARGETS)
    ) u_glyph_rom (
        .glyph_sel (glyph_sel),
        .glyph_idx (target_q),
        .col_sel   (col_q),
        .row_n     (row_n)
    );

endmodule

// File: tb/tb_dance_matrix_scanner.sv
// Directed bench for dance_matrix_scanner with a 4-cycle frame and 2-frame celebration.
module tb_dance_matrix_scanner;

    localparam int unsigned COLS         = 16;
    localparam int unsigned ROWS         = 16;
    localparam int unsigned NUM_TARGETS  = 4;
    localparam int unsigned FRAME_DIV    = 4;
    localparam int unsigned CELEB_FRAMES = 2;

`ifdef DANCE_SCORE_EN
    localparam int S_ONE = 1, S_TWO = 2, S_SAT = 255;
`else
    localparam int S_ONE = 0, S_TWO = 0, S_SAT = 0;
`endif

    // Pixel columns: rows 0..3 targets, 4 celebration A, 5 celebration B.
    localparam logic [15:0] TB_GLYPH [6][8] = '{
        '{16'h0180, 16'h03C0, 16'h07E0, 16'h0FF0, 16'h0180, 16'h0180, 16'h0180, 16'h0180},
        '{16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0FF0, 16'h07E0, 16'h03C0, 16'h0180},
        '{16'h0010, 16'h0030, 16'h0070, 16'h0FF0, 16'h0FF0, 16'h0070, 16'h0030, 16'h0010},
        '{16'h0800, 16'h0C00, 16'h0E00, 16'h0FF0, 16'h0FF0, 16'h0E00, 16'h0C00, 16'h0800},
        '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555},
        '{16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA}
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rand_num;
    logic        key_valid;
    logic [1:0]  key_idx;
    logic [3:0]  col_sel;
    logic [15:0] row_n;
    logic [1:0]  target;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [7:0]  score;

    int n_pass  = 0;
    int n_total = 0;
    int n_hits  = 0;
    int exp_t;

    always #5 clk = ~clk;

    dance_matrix_scanner #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .NUM_TARGETS  (NUM_TARGETS),
        .FRAME_DIV    (FRAME_DIV),
        .CELEB_FRAMES (CELEB_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rand_num   (rand_num),
        .key_valid  (key_valid),
        .key_idx    (key_idx),
        .col_sel    (col_sel),
        .row_n      (row_n),
        .target     (target),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score)
    );

    function automatic logic [15:0] exp_row(input int g, input int c);
        logic [15:0] px;
        px = (c < 8) ? TB_GLYPH[g][c] : 16'h0000;
        return ~px;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        rand_num  = 2'd2;
        key_valid = 1'b0;
        key_idx   = 2'd0;
        adv(2);
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_hit", 32'(hit_pulse), 32'd0);
        check_eq("rst_miss", 32'(miss_pulse), 32'd0);
        rst = 1'b0;

        // Cycles 0..16 after reset: column scan, target loads every 4 cycles.
        for (int k = 0; k <= 16; k++) begin
            exp_t = (k < 4) ? 0 : (k < 8) ? 2 : (k < 12) ? 1 : 2;
            check_eq($sformatf("scan_col_%0d", k), 32'(col_sel), 32'(k % 16));
            check_eq($sformatf("scan_tgt_%0d", k), 32'(target), 32'(exp_t));
            check_eq($sformatf("scan_row_%0d", k), 32'(row_n), 32'(exp_row(exp_t, k % 16)));
            rand_num = (k >= 5 && k <= 8) ? 2'd1 : 2'd2;
            adv(1);
        end

        // k=17: correct key for target 2.
        key_valid = 1'b1;
        key_idx   = 2'd2;
        adv(1);                                             // k=18
        check_eq("hit_pulse", 32'(hit_pulse), 32'd1);
        check_eq("hit_nomiss", 32'(miss_pulse), 32'd0);
        check_eq("hit_score", 32'(score), 32'(S_ONE));
        check_eq("celeb_a_c2", 32'(row_n), 32'(exp_row(4, 2)));
        key_valid = 1'b0;
        adv(1);                                             // k=19
        check_eq("hit_one_cycle", 32'(hit_pulse), 32'd0);
        check_eq("celeb_a_c3", 32'(row_n), 32'(exp_row(4, 3)));
        adv(1);                                             // k=20, first celeb tick seen
        check_eq("celeb_b_c4", 32'(row_n), 32'(exp_row(5, 4)));
        key_valid = 1'b1;
        key_idx   = 2'd2;
        adv(1);                                             // k=21
        check_eq("celeb_ign_hit", 32'(hit_pulse), 32'd0);
        check_eq("celeb_ign_miss", 32'(miss_pulse), 32'd0);
        check_eq("celeb_ign_score", 32'(score), 32'(S_ONE));
        key_valid = 1'b0;
        adv(2);                                             // k=23
        check_eq("celeb_b_c7", 32'(row_n), 32'(exp_row(5, 7)));
        adv(1);                                             // k=24, back in SHOW
        check_eq("ret_tgt", 32'(target), 32'd2);
        check_eq("ret_row_outside", 32'(row_n), 32'hFFFF);

        key_valid = 1'b1;
        key_idx   = 2'd1;
        adv(1);                                             // k=25
        check_eq("miss_pulse", 32'(miss_pulse), 32'd1);
        check_eq("miss_nohit", 32'(hit_pulse), 32'd0);
        check_eq("miss_score", 32'(score), 32'(S_ONE));
        check_eq("miss_tgt", 32'(target), 32'd2);
        key_valid = 1'b0;
        adv(1);                                             // k=26
        check_eq("miss_one_cycle", 32'(miss_pulse), 32'd0);

        adv(1);                                             // k=27 is a frame-tick cycle
        rand_num  = 2'd3;
        key_valid = 1'b1;
        key_idx   = 2'd2;
        adv(1);                                             // k=28
        check_eq("sim_hit", 32'(hit_pulse), 32'd1);
        check_eq("sim_tgt", 32'(target), 32'd2);
        check_eq("sim_score", 32'(score), 32'(S_TWO));
        key_valid = 1'b0;
        adv(4);                                             // k=32
        check_eq("sim_celeb_b_c0", 32'(row_n), 32'(exp_row(5, 0)));
        check_eq("sim_celeb_tgt", 32'(target), 32'd2);
        adv(4);                                             // k=36
        check_eq("sim_ret_tgt", 32'(target), 32'd3);
        check_eq("sim_ret_row", 32'(row_n), 32'(exp_row(3, 4)));

        // 260 hits; each celebration lasts at most 8 cycles.
        for (int i = 0; i < 260; i++) begin
            key_valid = 1'b1;
            key_idx   = 2'd3;
            adv(1);
            key_valid = 1'b0;
            if (hit_pulse) n_hits++;
            adv(9);
        end
        check_eq("sat_hits", 32'(n_hits), 32'd260);
        check_eq("sat_score", 32'(score), 32'(S_SAT));

        // Reset mid-celebration with a coincident key press.
        key_valid = 1'b1;
        key_idx   = 2'd3;
        adv(1);
        check_eq("pre_rst_hit", 32'(hit_pulse), 32'd1);
        rst = 1'b1;
        adv(1);
        check_eq("mid_rst_tgt", 32'(target), 32'd0);
        check_eq("mid_rst_col", 32'(col_sel), 32'd0);
        check_eq("mid_rst_score", 32'(score), 32'd0);
        check_eq("mid_rst_hit", 32'(hit_pulse), 32'd0);
        check_eq("mid_rst_miss", 32'(miss_pulse), 32'd0);
        check_eq("mid_rst_row", 32'(row_n), 32'(exp_row(0, 0)));
        rst       = 1'b0;
        key_valid = 1'b0;
        adv(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
